// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl
//  Description : Stopwatch mode controller. Turns the debounced start/stop and
//                lap/reset key levels into press / long-press events and runs
//                the IDLE/RUN/PAUSE/LAP sequencer that drives the time
//                counter (enable, clear) and the display (freeze, lap latch).
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
   parameter int LONG_TICKS = 2000,
   parameter int HOLD_W     = 11
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       tick_1k,
   input  logic       key_ss_n,
   input  logic       key_lr_n,
   output logic       count_en,
   output logic       count_clr,
   output logic       disp_freeze,
   output logic       lap_pulse,
   output logic [1:0] mode
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_LAP   = 2'd3
   } state_t;

   localparam logic [HOLD_W-1:0] c_LONG = HOLD_W'(LONG_TICKS);

   // Key history. Cleared to "pressed" so a key held through reset must be
   // released before it can produce an edge.
   logic              r_ss_prev;
   logic              r_lr_prev;

   logic [HOLD_W-1:0] r_hold;
   logic              r_long_fired;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_count_en;
   logic              r_count_clr;
   logic              r_disp_freeze;
   logic              r_lap_pulse;
   logic              w_clr_nxt;
   logic              w_lap_nxt;

   logic              w_ss_press;
   logic              w_lr_press;
   logic              w_lr_long;

   assign w_ss_press = r_ss_prev & ~key_ss_n;
   assign w_lr_press = r_lr_prev & ~key_lr_n;

   // The counter sits at LONG_TICKS once reached; the fired flag limits the
   // long event to the first cycle spent there.
   assign w_lr_long  = (r_hold == c_LONG) & ~r_long_fired;

   // Key history registers for falling-edge detection.
   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         r_ss_prev <= 1'b0;
         r_lr_prev <= 1'b0;
      end else begin
         r_ss_prev <= key_ss_n;
         r_lr_prev <= key_lr_n;
      end
   end

   // Lap/reset hold counter: counts 1 kHz ticks while held, saturates, and
   // is cleared together with the fired flag on release.
   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         r_hold       <= '0;
         r_long_fired <= 1'b0;
      end else if (key_lr_n) begin
         r_hold       <= '0;
         r_long_fired <= 1'b0;
      end else begin
         if (tick_1k && (r_hold != c_LONG)) begin
            r_hold <= r_hold + 1'b1;
         end
         if (w_lr_long) begin
            r_long_fired <= 1'b1;
         end
      end
   end

   // State register plus registered copies of every output.
   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         r_state       <= S_IDLE;
         r_count_en    <= 1'b0;
         r_count_clr   <= 1'b0;
         r_disp_freeze <= 1'b0;
         r_lap_pulse   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_count_en    <= (w_state_nxt == S_RUN) || (w_state_nxt == S_LAP);
         r_count_clr   <= w_clr_nxt;
         r_disp_freeze <= (w_state_nxt == S_LAP);
         r_lap_pulse   <= w_lap_nxt;
      end
   end

   // Next-state and pulse decode. Long press outranks start/stop, which
   // outranks a short lap/reset press arriving in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_clr_nxt   = 1'b0;
      w_lap_nxt   = 1'b0;
      if (w_lr_long) begin
         // A long press in IDLE is swallowed, including any coincident edge.
         if (r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
            w_clr_nxt   = 1'b1;
         end
      end else if (w_ss_press) begin
         case (r_state)
            S_IDLE:  w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_PAUSE;
            S_PAUSE: w_state_nxt = S_RUN;
            S_LAP:   w_state_nxt = S_PAUSE;
            default: w_state_nxt = S_IDLE;
         endcase
      end else if (w_lr_press) begin
         case (r_state)
            S_RUN: begin
               w_state_nxt = S_LAP;
               w_lap_nxt   = 1'b1;
            end
            S_LAP:   w_state_nxt = S_RUN;
            S_PAUSE: begin
               w_state_nxt = S_IDLE;
               w_clr_nxt   = 1'b1;
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   assign count_en    = r_count_en;
   assign count_clr   = r_count_clr;
   assign disp_freeze = r_disp_freeze;
   assign lap_pulse   = r_lap_pulse;
   assign mode        = r_state;

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Mode controller for the stopwatch.
- Consumes the two debounced, active-low push-button levels: start/stop and lap/reset.
- Detects press edges and long presses on those levels.
- Sequences the time counter and the display path: count enable, synchronous clear, display freeze.
- Sits between the key debouncers and the BCD time counter / seven-segment display logic.

Parameters:
- LONG_TICKS, 2000: number of tick_1k pulses lap/reset must be held continuously to count as a long press (2 s at 1 kHz).
- HOLD_W, 11: width of the hold counter; must satisfy 2^HOLD_W > LONG_TICKS.

Ports:
- CLOCK  input  1  system clock; all state updates on posedge.
- RESET  input  1  synchronous, active-low reset.
- tick_1k  input  1  one-CLOCK-wide enable pulse at 1 kHz; used only by the hold counter.
- key_ss_n  input  1  debounced start/stop level; 0 = pressed.
- key_lr_n  input  1  debounced lap/reset level; 0 = pressed.
- count_en  output  1  time counter increments while 1.
- count_clr  output  1  one-cycle pulse; time counter clears to 0.
- disp_freeze  output  1  display holds its latched value while 1.
- lap_pulse  output  1  one-cycle pulse; display latches the current time.
- mode  output  2  current state: 0 IDLE, 1 RUN, 2 PAUSE, 3 LAP.

Behaviour:

Reset:
- RESET=0 at a posedge forces the following, regardless of key inputs:
  - mode=IDLE, count_en=0, count_clr=0, disp_freeze=0, lap_pulse=0.
  - hold counter=0, long-fired flag=0.
  - key history registers ss_prev=0, lr_prev=0.
- Consequence: a key held through reset produces no press event until it is released and pressed again.
- Reset mid-operation discards the current state; no clear pulse is emitted.

Press detection:
- ss_press = ss_prev & ~key_ss_n, evaluated each cycle. ss_prev <= key_ss_n every cycle.
- lr_press is formed the same way from key_lr_n and lr_prev.
- A press event is one cycle wide.

Hold counter:
- While key_lr_n=0 and tick_1k=1, the counter increments and saturates at LONG_TICKS.
- On key_lr_n=1 the counter clears to 0 and the long-fired flag clears.
- lr_long asserts for exactly one cycle: the cycle the counter reaches LONG_TICKS with long-fired=0. long-fired is then set.

Latency and output timing:
- An event in cycle n produces the new mode and outputs after posedge n+1. All outputs are registered.
- count_en = 1 in RUN and LAP.
- disp_freeze = 1 in LAP only.

FSM (priority top to bottom within a cycle):
- lr_long, mode != IDLE -> IDLE, count_clr=1 for one cycle.
- lr_long in IDLE -> no action.
- ss_press:
  - IDLE -> RUN.
  - RUN -> PAUSE.
  - PAUSE -> RUN.
  - LAP -> PAUSE (unfreeze; display shows stopped count).
- lr_press (only if no ss_press in the same cycle; a simultaneous lr_press is dropped, but its hold counter still runs):
  - RUN -> LAP, lap_pulse=1 for one cycle.
  - LAP -> RUN (unfreeze).
  - PAUSE -> IDLE, count_clr=1 for one cycle.
  - IDLE -> no action.
- Long press from RUN: the short press first moves RUN->LAP at the press edge, then lr_long moves LAP->IDLE with a clear. This is required behaviour.

Boundaries:
- A key held past LONG_TICKS fires lr_long once, never again until release.
- Release exactly at tick LONG_TICKS-1: no long event.
- tick_1k has no effect on the FSM except through the hold counter.

Test Plan (LONG_TICKS=4, tick_1k every 10 cycles):
- Reset with both keys high, then pulse key_ss_n low for 20 cycles -> mode=1 and count_en=1 one cycle after the falling edge; release causes no change.
- From RUN, press lr -> mode=3, lap_pulse high exactly 1 cycle, disp_freeze=1. Press lr again -> mode=1, disp_freeze=0.
- From RUN, press ss, then press lr -> mode=2 with count_en=0, then mode=0 with count_clr pulsed exactly 1 cycle.
- From RUN, hold lr for 50 cycles -> mode=3 at the press edge; after the 4th tick, mode=0 and count_clr 1 cycle. No further pulses while held; hold counter is 0 after release.
- key_ss_n and key_lr_n fall in the same cycle while in RUN -> mode=2, no lap_pulse.
- Hold ss low across RESET=0, then release RESET -> mode=0, no event until ss is released and pressed again, then mode=1.
